// File: rtl/mos6502_pkg.sv
`default_nettype none
// ============================================================
// mos6502_pkg: shared register-select codes, sequence kinds,
// stack/vector constants and the interrupt sequencer state set.
// Rev 1.0
// ============================================================
package mos6502_pkg;

    localparam logic [2:0] C_RF_A   = 3'd0;
    localparam logic [2:0] C_RF_X   = 3'd1;
    localparam logic [2:0] C_RF_Y   = 3'd2;
    localparam logic [2:0] C_RF_SP  = 3'd3;
    localparam logic [2:0] C_RF_PCL = 3'd4;
    localparam logic [2:0] C_RF_PCH = 3'd5;
    localparam logic [2:0] C_RF_PSR = 3'd6;

    localparam logic [7:0]  C_STACK_PAGE = 8'h01;
    localparam logic [15:0] C_VEC_NMI    = 16'hFFFA;
    localparam logic [15:0] C_VEC_RESET  = 16'hFFFC;
    localparam logic [15:0] C_VEC_IRQ    = 16'hFFFE;

    typedef enum logic [1:0] {
        KIND_IRQ   = 2'd0,
        KIND_NMI   = 2'd1,
        KIND_BRK   = 2'd2,
        KIND_RESET = 2'd3
    } seq_kind_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WAIT   = 4'd1,
        ST_R_SP1  = 4'd2,
        ST_R_SP2  = 4'd3,
        ST_R_SP3  = 4'd4,
        ST_PUSH_H = 4'd5,
        ST_PUSH_L = 4'd6,
        ST_PUSH_P = 4'd7,
        ST_SET_I  = 4'd8,
        ST_RD_LO  = 4'd9,
        ST_WR_LO  = 4'd10,
        ST_RD_HI  = 4'd11,
        ST_WR_HI  = 4'd12
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/nmi_edge_latch.sv
`default_nettype none
// ============================================================
// nmi_edge_latch: NMI rising-edge detector with pending flag.
// Rev 1.0
// ============================================================
module nmi_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic nmi,
    input  logic clr,
    output logic pending
);

    logic r_nmi_prev;
    logic r_pending;
    logic w_edge;

    assign w_edge  = nmi & ~r_nmi_prev;
    // An edge in the current cycle counts as pending so it can win the same boundary.
    assign pending = r_pending | w_edge;

    // Previous level resets high so a line already high at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nmi_prev <= 1'b1;
            r_pending  <= 1'b0;
        end else begin
            r_nmi_prev <= nmi;
            r_pending  <= (r_pending | w_edge) & ~clr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_sequencer.sv
`default_nettype none
// ============================================================
// interrupt_sequencer: drives the register file and memory bus
// through the 6502 RESET/NMI/IRQ/BRK entry sequence.
// Rev 1.0
// ============================================================
module interrupt_sequencer
    import mos6502_pkg::*;
#(
    parameter logic [7:0]  STACK_PAGE = C_STACK_PAGE,
    parameter logic [15:0] VEC_NMI    = C_VEC_NMI,
    parameter logic [15:0] VEC_RESET  = C_VEC_RESET,
    parameter logic [15:0] VEC_IRQ    = C_VEC_IRQ
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_boundary,
    input  logic        irq,
    input  logic        nmi,
    input  logic        brk_req,
    input  logic [15:0] pc,
    input  logic [7:0]  psr,
    input  logic [7:0]  sp,
    input  logic [7:0]  mem_rdata,
    output logic        rf_load,
    output logic [2:0]  rf_sel,
    output logic [7:0]  rf_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        seq_busy,
    output logic        seq_done,
    output logic [1:0]  seq_kind
);

    seq_state_t  r_state;
    seq_kind_t   r_kind;
    logic [15:0] r_pc_q;
    logic        r_done;

    logic        w_nmi_pending;
    logic        w_at_boundary;
    logic        w_take_nmi;
    logic        w_take_brk;
    logic        w_take_irq;
    logic [15:0] w_vec;
    logic [7:0]  w_push_psr;

    assign w_at_boundary = (r_state == ST_IDLE) && instr_boundary;
    assign w_take_nmi    = w_at_boundary && w_nmi_pending;
    assign w_take_brk    = w_at_boundary && !w_nmi_pending && brk_req;
    assign w_take_irq    = w_at_boundary && !w_nmi_pending && !brk_req && irq && !psr[2];

    nmi_edge_latch u_nmi_edge_latch (
        .clk     (clk),
        .reset   (reset),
        .nmi     (nmi),
        .clr     (w_take_nmi),
        .pending (w_nmi_pending)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_kind  <= KIND_RESET;
            r_pc_q  <= 16'h0000;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take_nmi || w_take_brk || w_take_irq) begin
                        r_pc_q  <= pc;
                        r_state <= ST_PUSH_H;
                        r_kind  <= w_take_nmi ? KIND_NMI :
                                   w_take_brk ? KIND_BRK : KIND_IRQ;
                    end
                end
                ST_WAIT:   r_state <= ST_R_SP1;
                ST_R_SP1:  r_state <= ST_R_SP2;
                ST_R_SP2:  r_state <= ST_R_SP3;
                ST_R_SP3:  r_state <= ST_SET_I;
                ST_PUSH_H: r_state <= ST_PUSH_L;
                ST_PUSH_L: r_state <= ST_PUSH_P;
                ST_PUSH_P: r_state <= ST_SET_I;
                ST_SET_I:  r_state <= ST_RD_LO;
                ST_RD_LO:  r_state <= ST_WR_LO;
                ST_WR_LO:  r_state <= ST_RD_HI;
                ST_RD_HI:  r_state <= ST_WR_HI;
                ST_WR_HI: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_kind)
            KIND_NMI:   w_vec = VEC_NMI;
            KIND_RESET: w_vec = VEC_RESET;
            default:    w_vec = VEC_IRQ;
        endcase
    end

    // Pushed status always has bit 5 set; bit 4 distinguishes BRK from hardware interrupts.
    assign w_push_psr = {psr[7:6], 1'b1, (r_kind == KIND_BRK), psr[3:0]};

    always_comb begin
        rf_load   = 1'b0;
        rf_sel    = C_RF_A;
        rf_data   = 8'h00;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (r_state)
            ST_R_SP1, ST_R_SP2, ST_R_SP3,
            ST_PUSH_H, ST_PUSH_L, ST_PUSH_P: begin
                rf_load = 1'b1;
                rf_sel  = C_RF_SP;
                rf_data = sp - 8'd1;
                if (r_state == ST_PUSH_H || r_state == ST_PUSH_L || r_state == ST_PUSH_P) begin
                    mem_addr  = {STACK_PAGE, sp};
                    mem_we    = 1'b1;
                    mem_wdata = (r_state == ST_PUSH_H) ? r_pc_q[15:8] :
                                (r_state == ST_PUSH_L) ? r_pc_q[7:0]  : w_push_psr;
                end
            end
            ST_SET_I: begin
                rf_load = 1'b1;
                rf_sel  = C_RF_PSR;
                rf_data = psr | 8'h04;
            end
            ST_RD_LO: begin
                mem_addr = w_vec;
                mem_re   = 1'b1;
            end
            ST_WR_LO: begin
                rf_load = 1'b1;
                rf_sel  = C_RF_PCL;
                rf_data = mem_rdata;
            end
            ST_RD_HI: begin
                mem_addr = w_vec + 16'd1;
                mem_re   = 1'b1;
            end
            ST_WR_HI: begin
                rf_load = 1'b1;
                rf_sel  = C_RF_PCH;
                rf_data = mem_rdata;
            end
            default: ;
        endcase
    end

    assign seq_busy = (r_state != ST_IDLE);
    assign seq_done = r_done;
    assign seq_kind = r_kind;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// ============================================================
// tb_interrupt_sequencer: register-file/memory environment plus
// transaction-level expectations for the entry sequences.
// Rev 1.0
// ============================================================
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_boundary = 1'b0;
    logic        irq = 1'b0;
    logic        nmi = 1'b0;
    logic        brk_req = 1'b0;
    logic [15:0] m_pc;
    logic [7:0]  m_psr;
    logic [7:0]  m_sp;
    logic [7:0]  mem_rdata = 8'h00;
    logic        rf_load;
    logic [2:0]  rf_sel;
    logic [7:0]  rf_data;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        seq_busy;
    logic        seq_done;
    logic [1:0]  seq_kind;

    // Environment state: preload port, stack page image, vector bytes FFFA..FFFF, write logs.
    logic        preload = 1'b0;
    logic [15:0] pre_pc = 16'h0;
    logic [7:0]  pre_psr = 8'h0;
    logic [7:0]  pre_sp = 8'h0;
    logic [7:0]  stk [0:255];
    logic [7:0]  vec [0:5];
    logic [7:0]  sp_hist [0:15];
    int          sp_wr_cnt = 0;
    int          we_cnt = 0;
    int          bad_page_cnt = 0;
    int          other_wr_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    interrupt_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .instr_boundary (instr_boundary),
        .irq            (irq),
        .nmi            (nmi),
        .brk_req        (brk_req),
        .pc             (m_pc),
        .psr            (m_psr),
        .sp             (m_sp),
        .mem_rdata      (mem_rdata),
        .rf_load        (rf_load),
        .rf_sel         (rf_sel),
        .rf_data        (rf_data),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .seq_kind       (seq_kind)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_mem(input logic [15:0] a);
        if (a >= 16'hFFFA) return vec[a - 16'hFFFA];
        return 8'hEE;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            m_pc  <= pre_pc;
            m_psr <= pre_psr;
            m_sp  <= pre_sp;
        end else if (rf_load) begin
            case (rf_sel)
                3'd3: begin
                    m_sp <= rf_data;
                    sp_hist[sp_wr_cnt[3:0]] <= rf_data;
                    sp_wr_cnt <= sp_wr_cnt + 1;
                end
                3'd4:    m_pc[7:0]  <= rf_data;
                3'd5:    m_pc[15:8] <= rf_data;
                3'd6:    m_psr      <= rf_data;
                default: other_wr_cnt <= other_wr_cnt + 1;
            endcase
        end
        if (mem_we) begin
            stk[mem_addr[7:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
            if (mem_addr[15:8] != 8'h01) bad_page_cnt <= bad_page_cnt + 1;
        end
        if (mem_re) mem_rdata <= rd_mem(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload_regs(input logic [15:0] p, input logic [7:0] s, input logic [7:0] st);
        pre_pc = p; pre_psr = s; pre_sp = st; preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    // Releases reset just after an edge, then expects WAIT + 3 SP writes + vector fetch.
    task automatic reset_seq(input string tag);
        int base, we0, cnt;
        logic [7:0] sp0, psr0;
        @(posedge clk); #1 reset = 1'b0;
        sp0 = m_sp; psr0 = m_psr; base = sp_wr_cnt; we0 = we_cnt;
        @(negedge clk);
        cnt = 0;
        while (seq_busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, cnt, 9);
        check({tag, " done"}, {31'd0, seq_done}, 1);
        check({tag, " kind"}, {30'd0, seq_kind}, 3);
        check({tag, " sp_wr1"}, {24'd0, sp_hist[(base + 0) & 15]}, {24'd0, sp0 - 8'd1});
        check({tag, " sp_wr2"}, {24'd0, sp_hist[(base + 1) & 15]}, {24'd0, sp0 - 8'd2});
        check({tag, " sp_wr3"}, {24'd0, sp_hist[(base + 2) & 15]}, {24'd0, sp0 - 8'd3});
        check({tag, " no_mem_we"}, we_cnt - we0, 0);
        check({tag, " psr"}, {24'd0, m_psr}, {24'd0, psr0 | 8'h04});
        check({tag, " pc"}, {16'd0, m_pc}, {16'd0, vec[3], vec[2]});
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, seq_done}, 0);
    endtask

    // Triggers one entry at a boundary and checks pushes, SP, PSR, PC and timing.
    task automatic run_seq(input string tag, input logic t_irq, input logic t_nmi,
                           input logic t_brk, input logic hold, input logic nmi_mid,
                           input logic [1:0] exp_kind);
        logic [15:0] pc0;
        logic [7:0]  psr0, sp0, exp_p;
        int          we0, cnt, seen;
        pc0 = m_pc; psr0 = m_psr; sp0 = m_sp; we0 = we_cnt;
        irq = t_irq; brk_req = t_brk; instr_boundary = 1'b1;
        if (t_nmi) nmi = 1'b1;
        @(negedge clk);
        brk_req = 1'b0;
        if (!hold) begin instr_boundary = 1'b0; irq = 1'b0; end
        check({tag, " kind"}, {30'd0, seq_kind}, {30'd0, exp_kind});
        cnt = 0;
        while (seq_busy === 1'b1 && cnt < 40) begin
            cnt++;
            if (nmi_mid && cnt == 3) nmi = 1'b1;
            if (nmi_mid && cnt == 5) nmi = 1'b0;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, cnt, 8);
        check({tag, " done"}, {31'd0, seq_done}, 1);
        exp_p = (psr0 | 8'h20) & 8'hEF;
        if (exp_kind == 2'd2) exp_p = exp_p | 8'h10;
        check({tag, " push_pch"}, {24'd0, stk[sp0]}, {24'd0, pc0[15:8]});
        check({tag, " push_pcl"}, {24'd0, stk[sp0 - 8'd1]}, {24'd0, pc0[7:0]});
        check({tag, " push_psr"}, {24'd0, stk[sp0 - 8'd2]}, {24'd0, exp_p});
        check({tag, " we_count"}, we_cnt - we0, 3);
        check({tag, " sp"}, {24'd0, m_sp}, {24'd0, sp0 - 8'd3});
        check({tag, " psr"}, {24'd0, m_psr}, {24'd0, psr0 | 8'h04});
        if (exp_kind == 2'd1) check({tag, " pc"}, {16'd0, m_pc}, {16'd0, vec[1], vec[0]});
        else                  check({tag, " pc"}, {16'd0, m_pc}, {16'd0, vec[5], vec[4]});
        @(negedge clk);
        check({tag, " done_pulse"}, {31'd0, seq_done}, 0);
        if (hold) begin
            seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (seq_busy !== 1'b0) seen++;
            end
            check({tag, " masked_after"}, seen, 0);
        end
        irq = 1'b0; instr_boundary = 1'b0; nmi = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        logic [15:0] rp;
        vec[0] = 8'($urandom); vec[1] = 8'($urandom);
        vec[2] = 8'h00;        vec[3] = 8'hC0;
        vec[4] = 8'($urandom); vec[5] = 8'($urandom);

        preload_regs(16'h0000, 8'h00, 8'h00);
        @(negedge clk);
        check("rst busy", {31'd0, seq_busy}, 1);
        check("rst kind", {30'd0, seq_kind}, 3);
        check("rst strobes", {29'd0, rf_load, mem_we, mem_re}, 0);
        check("rst done", {31'd0, seq_done}, 0);
        check("rst addr", {16'd0, mem_addr}, 0);
        check("rst data", {13'd0, rf_sel, rf_data, mem_wdata}, 0);

        reset_seq("reset");

        preload_regs(16'h1234, 8'h00, 8'hFD);
        run_seq("irq_spec", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            preload_regs(16'($urandom), 8'($urandom) & 8'hFB, 8'($urandom));
            run_seq("irq_rand", 1'b1, 1'b0, 1'b0, (i % 2) == 1, 1'b0, 2'd0);
        end

        // IRQ held at a boundary with I set must not start anything.
        preload_regs(16'h4321, 8'h04, 8'h80);
        irq = 1'b1; instr_boundary = 1'b1; seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (seq_busy !== 1'b0 || rf_load !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) seen++;
        end
        check("irq_masked", seen, 0);
        irq = 1'b0; instr_boundary = 1'b0;

        // BRK away from a boundary is ignored.
        brk_req = 1'b1;
        @(negedge clk);
        brk_req = 1'b0; seen = 0;
        repeat (4) begin
            if (seq_busy !== 1'b0) seen++;
            @(negedge clk);
        end
        check("brk_no_boundary", seen, 0);

        preload_regs(16'hABCD, 8'h00, 8'h40);
        run_seq("nmi_irq_same", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);

        preload_regs(16'hBEEF, 8'hC3, 8'h00);
        run_seq("brk_spec", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            preload_regs(16'($urandom), 8'($urandom), 8'($urandom));
            run_seq("brk_rand", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        end

        // NMI edge during an IRQ sequence is taken at the next boundary.
        preload_regs(16'($urandom), 8'($urandom) & 8'hFB, 8'($urandom));
        run_seq("irq_nmi_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        run_seq("nmi_pended", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);

        // Reset asserted during PUSH_L, with an NMI edge already pending.
        rp = 16'($urandom);
        preload_regs(rp, 8'h00, 8'($urandom));
        irq = 1'b1; instr_boundary = 1'b1;
        @(negedge clk);
        irq = 1'b0; instr_boundary = 1'b0; nmi = 1'b1;
        @(negedge clk);
        check("mid_pushl_we", {31'd0, mem_we}, 1);
        nmi = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst strobes", {29'd0, rf_load, mem_we, mem_re}, 0);
        check("mid_rst busy_kind", {29'd0, seq_busy, seq_kind}, 7);
        repeat (2) @(posedge clk);
        reset_seq("mid_reset");
        instr_boundary = 1'b1; seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (seq_busy !== 1'b0) seen++;
        end
        check("nmi_cleared_by_reset", seen, 0);
        instr_boundary = 1'b0;

        check("stack_page", bad_page_cnt, 0);
        check("no_axy_writes", other_wr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
